// File: rtl/ysyx_23060191_gpr_file.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ysyx_23060191_gpr_file : 32-entry GPR file (x0 = 0), wb bypass, RAW scoreboard
// Revision: 1.0
// ----------------------------------------------------------------------------
module ysyx_23060191_gpr_file #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wb_en,
  input  logic [4:0]            wb_rd_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_rd,
  output logic                  issue_ready,
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  wb_underflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] data_w [32];
  logic [CNT_WIDTH-1:0]  cnt_w  [32];
  logic [31:0]           dec;
  logic [31:0]           inc;
  logic                  underflow_q;
  logic                  underflow_hit;

  assign data_w[0] = '0;
  assign cnt_w[0]  = CNT_ZERO;
  assign dec[0]    = 1'b0;
  assign inc[0]    = 1'b0;

  generate
    for (genvar r = 1; r < 32; r++) begin : g_reg
      logic [DATA_WIDTH-1:0] data_q;
      logic [CNT_WIDTH-1:0]  cnt_q;
      logic                  wb_hit;

      assign wb_hit    = wb_en && (wb_rd_addr == 5'(r));
      assign dec[r]    = wb_hit && (cnt_q != CNT_ZERO);
      assign inc[r]    = issue_valid && issue_ready && (issue_rd == 5'(r));
      assign data_w[r] = data_q;
      assign cnt_w[r]  = cnt_q;

      always_ff @(posedge clk) begin
        if (!rstn) begin
          data_q <= '0;
        end else if (wb_hit) begin
          data_q <= wb_data;
        end
      end

      // Simultaneous reserve and retire on one register cancel out.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          cnt_q <= CNT_ZERO;
        end else if (inc[r] && !dec[r]) begin
          cnt_q <= cnt_q + CNT_ONE;
        end else if (dec[r] && !inc[r]) begin
          cnt_q <= cnt_q - CNT_ONE;
        end
      end
    end
  endgenerate

  // A full counter can still accept a reservation if it retires one this cycle.
  assign issue_ready = (issue_rd == 5'd0) || (cnt_w[issue_rd] != CNT_MAX) || dec[issue_rd];

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [4:0] addr);
    logic [DATA_WIDTH-1:0] val;
    val = data_w[addr];
    if (addr == 5'd0) begin
      val = '0;
    end else if (wb_en && (wb_rd_addr == addr)) begin
      val = wb_data;
    end
    return val;
  endfunction

  function automatic logic busy_port(input logic [4:0] addr);
    logic [CNT_WIDTH-1:0] remain;
    remain = cnt_w[addr] - (dec[addr] ? CNT_ONE : CNT_ZERO);
    return (addr != 5'd0) && (remain != CNT_ZERO);
  endfunction

  assign rs1_data = read_port(rs1_addr);
  assign rs2_data = read_port(rs2_addr);
  assign rs1_busy = busy_port(rs1_addr);
  assign rs2_busy = busy_port(rs2_addr);

  assign underflow_hit = wb_en && (wb_rd_addr != 5'd0) && (cnt_w[wb_rd_addr] == CNT_ZERO);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      underflow_q <= 1'b0;
    end else if (underflow_hit) begin
      underflow_q <= 1'b1;
    end
  end

  assign wb_underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060191_gpr_file.sv
`default_nettype none
// Directed self-checking bench for ysyx_23060191_gpr_file.
module tb_ysyx_23060191_gpr_file;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wb_en;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        wb_underflow;

  int checks = 0;
  int errors = 0;

  ysyx_23060191_gpr_file #(.DATA_WIDTH(32), .CNT_WIDTH(2)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .wb_en        (wb_en),
    .wb_rd_addr   (wb_rd_addr),
    .wb_data      (wb_data),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_ready  (issue_ready),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .wb_underflow (wb_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn = 1'b0; wb_en = 1'b0; wb_rd_addr = 5'd0; wb_data = 32'h0;
    issue_valid = 1'b0; issue_rd = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    tick();
    tick();
    rstn = 1'b1;
    #1;
    chk("reset_underflow", 32'(wb_underflow), 32'h0);
    for (int i = 1; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(i);
      #1;
      chk("reset_rs1_data", rs1_data, 32'h0);
      chk("reset_rs2_data", rs2_data, 32'h0);
      chk("reset_rs1_busy", 32'(rs1_busy), 32'h0);
      chk("reset_rs2_busy", 32'(rs2_busy), 32'h0);
    end

    // x0 write discarded, no underflow
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    wb_en = 1'b1; wb_rd_addr = 5'd0; wb_data = 32'hDEADBEEF;
    #1;
    chk("x0_bypass", rs1_data, 32'h0);
    tick();
    wb_en = 1'b0;
    #1;
    chk("x0_read", rs1_data, 32'h0);
    chk("x0_underflow", 32'(wb_underflow), 32'h0);

    // bypass on x5
    issue_valid = 1'b1; issue_rd = 5'd5;
    #1;
    chk("x5_issue_ready", 32'(issue_ready), 32'h1);
    tick();
    issue_valid = 1'b0; rs1_addr = 5'd5;
    #1;
    chk("x5_busy_pending", 32'(rs1_busy), 32'h1);
    wb_en = 1'b1; wb_rd_addr = 5'd5; wb_data = 32'h12345678;
    #1;
    chk("x5_bypass_data", rs1_data, 32'h12345678);
    chk("x5_bypass_busy", 32'(rs1_busy), 32'h0);
    tick();
    wb_en = 1'b0;
    #1;
    chk("x5_array_data", rs1_data, 32'h12345678);
    chk("x5_busy_after", 32'(rs1_busy), 32'h0);

    // counting on x7
    issue_valid = 1'b1; issue_rd = 5'd7; rs2_addr = 5'd7;
    tick(); tick(); tick();
    #1;
    chk("x7_busy_cnt3", 32'(rs2_busy), 32'h1);
    chk("x7_ready_full", 32'(issue_ready), 32'h0);
    tick();
    wb_en = 1'b1; wb_rd_addr = 5'd7; wb_data = 32'h70;
    #1;
    chk("x7_ready_with_dec", 32'(issue_ready), 32'h1);
    chk("x7_busy_with_dec", 32'(rs2_busy), 32'h1);
    tick();
    wb_en = 1'b0;
    #1;
    chk("x7_still_full", 32'(issue_ready), 32'h0);
    issue_valid = 1'b0;
    wb_en = 1'b1; wb_data = 32'h71;
    #1;
    chk("x7_commit1_busy", 32'(rs2_busy), 32'h1);
    tick();
    wb_data = 32'h72;
    #1;
    chk("x7_commit2_busy", 32'(rs2_busy), 32'h1);
    tick();
    wb_data = 32'h73;
    #1;
    chk("x7_commit3_busy", 32'(rs2_busy), 32'h0);
    chk("x7_commit3_data", rs2_data, 32'h73);
    tick();
    wb_en = 1'b0;
    #1;
    chk("x7_idle_busy", 32'(rs2_busy), 32'h0);
    chk("x7_idle_data", rs2_data, 32'h73);
    chk("x7_no_underflow", 32'(wb_underflow), 32'h0);

    // underflow on x9
    wb_en = 1'b1; wb_rd_addr = 5'd9; wb_data = 32'hA5;
    tick();
    wb_en = 1'b0; rs1_addr = 5'd9;
    #1;
    chk("x9_data", rs1_data, 32'hA5);
    chk("x9_underflow_set", 32'(wb_underflow), 32'h1);
    chk("x9_busy", 32'(rs1_busy), 32'h0);
    tick(); tick();
    chk("x9_underflow_sticky", 32'(wb_underflow), 32'h1);

    // mid-operation reset
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick(); tick();
    issue_valid = 1'b0; rs1_addr = 5'd3;
    #1;
    chk("x3_busy_before", 32'(rs1_busy), 32'h1);
    wb_en = 1'b1; wb_rd_addr = 5'd3; wb_data = 32'hFF; rstn = 1'b0;
    tick();
    rstn = 1'b1; wb_en = 1'b0; issue_valid = 1'b1; issue_rd = 5'd3;
    #1;
    chk("x3_data_after_rst", rs1_data, 32'h0);
    chk("x3_busy_after_rst", 32'(rs1_busy), 32'h0);
    chk("x3_ready_after_rst", 32'(issue_ready), 32'h1);
    chk("underflow_cleared", 32'(wb_underflow), 32'h0);
    chk("x9_cleared", dut.data_w[9], 32'h0);
    issue_valid = 1'b0;

    // dual port on x10
    issue_valid = 1'b1; issue_rd = 5'd10;
    tick();
    issue_valid = 1'b0; rs1_addr = 5'd10; rs2_addr = 5'd10;
    #1;
    chk("x10_rs1_busy_pend", 32'(rs1_busy), 32'h1);
    chk("x10_rs2_busy_pend", 32'(rs2_busy), 32'h1);
    wb_en = 1'b1; wb_rd_addr = 5'd10; wb_data = 32'h55AA;
    #1;
    chk("x10_rs1_bypass", rs1_data, 32'h55AA);
    chk("x10_rs2_bypass", rs2_data, 32'h55AA);
    chk("x10_rs1_busy", 32'(rs1_busy), 32'h0);
    chk("x10_rs2_busy", 32'(rs2_busy), 32'h0);
    tick();
    wb_en = 1'b0;
    #1;
    chk("x10_rs1_array", rs1_data, 32'h55AA);
    chk("x10_rs2_array", rs2_data, 32'h55AA);
    chk("x10_no_underflow", 32'(wb_underflow), 32'h0);

    // issue to x0 always accepted
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    chk("x0_issue_ready", 32'(issue_ready), 32'h1);
    issue_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
